router_1xn: RTL

ROUTER_1XN -- requirements
Module: router_1xn

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_fifo.sv | 116 +++++++++++
 rtl/router_1xn.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1xN packet router.
//   state_e          - sequencing FSM states
//   DEF_*            - default parameter values
//   hdr_addr_width() - width of the destination-address field of a header byte
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_FULL = 3'd2,
        ST_PARITY    = 3'd3,
        ST_DROP      = 3'd4
    } state_e;

    localparam int DEF_N       = 3;
    localparam int DEF_DW      = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 30;

    // Address field is clog2(n) bits wide, never narrower than one bit.
    function automatic int hdr_addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-channel output FIFO with registered read data and an idle-read timeout.
// Ports:
//   clk, resetn     - clock, asynchronous active-low reset
//   wr_en, wr_data  - write strobe and byte (ignored while full)
//   rd_en           - read strobe (ignored while empty); rd_data updates next edge
//   rd_data         - registered read data
//   vld             - FIFO not empty
//   full            - FIFO holds DEPTH entries
// A channel that stays non-empty and unread for TIMEOUT cycles is flushed:
// emptied, rd_data zeroed, timer cleared. A write landing on the flush cycle
// survives as the only entry.
module router_fifo #(
    parameter int DW      = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          vld,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] mem [DEPTH];

    logic          empty;
    logic          do_wr;
    logic          do_rd;
    logic          flush;
    logic [PW-1:0] mem_wr_idx;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign vld     = ~empty;
    assign rd_data = dout_q;
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign flush   = (timer_q == TW'(TIMEOUT));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        timer_d    = timer_q;
        mem_wr_idx = wr_ptr_q;

        if (flush) begin
            rd_ptr_d = '0;
            dout_d   = '0;
            timer_d  = '0;
            if (do_wr) begin
                mem_wr_idx = '0;
                wr_ptr_d   = PW'(1);
                count_d    = CW'(1);
            end else begin
                wr_ptr_d = '0;
                count_d  = '0;
            end
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                dout_d   = mem[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // Timer measures how long data has sat unread.
            if (empty || do_rd) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            timer_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            timer_q  <= timer_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[mem_wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/router_1xn.sv
// 1-to-N packet router. A packet is a header byte (destination address in the
// low bits, length above), payload bytes, then a parity byte marked by
// packet_valid=0. The packet is steered into the addressed channel FIFO;
// illegal addresses are discarded.
// Ports:
//   clk, resetn   - clock, asynchronous active-low reset
//   packet_valid  - high for header/payload bytes, low on the parity byte
//   datain        - input byte, consumed only when busy=0
//   read_enb      - per-channel read strobes
//   data_out      - channel k read data at [k*DW +: DW]
//   vld_out       - per-channel FIFO not empty
//   err           - parity mismatch on the last completed packet
//   busy          - source must hold datain/packet_valid
//   dropped       - single-cycle pulse on an illegal-address header
//
// state        | meaning
// ST_IDLE      | waiting for a header byte
// ST_LOAD      | forwarding payload bytes and the parity byte
// ST_WAIT_FULL | target FIFO full, byte held off; resumes prev_q when space frees
// ST_PARITY    | one busy cycle to compare computed and received parity
// ST_DROP      | discarding a packet with an illegal address
module router_1xn
    import router_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DW      = DEF_DW,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            packet_valid,
    input  logic [DW-1:0]   datain,
    input  logic [N-1:0]    read_enb,
    output logic [N*DW-1:0] data_out,
    output logic [N-1:0]    vld_out,
    output logic            err,
    output logic            busy,
    output logic            dropped
);

    localparam int AW = hdr_addr_width(N);
    localparam int NP = 1 << AW;
    localparam logic [AW:0] N_LIM = (AW + 1)'(N);

    state_e        state_q, state_d;
    state_e        prev_q, prev_d;
    state_e        eff_state;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] parity_q, parity_d;
    logic [DW-1:0] rx_par_q, rx_par_d;
    logic          err_q, err_d;

    logic [AW-1:0] hdr_addr;
    logic          hdr_legal;
    logic [NP-1:0] full_pad;
    logic [NP-1:0] wr_pad;
    logic [N-1:0]  fifo_full;
    logic [N-1:0]  fifo_wr;
    logic          wr_en;
    logic [AW-1:0] wr_sel;
    logic          busy_c;
    logic          dropped_c;

    assign hdr_addr  = datain[AW-1:0];
    assign hdr_legal = ({1'b0, hdr_addr} < N_LIM);

    // Pad per-channel vectors to a power of two so any address indexes safely.
    always_comb begin
        full_pad         = '0;
        full_pad[N-1:0]  = fifo_full;
        wr_pad           = '0;
        if (wr_en) begin
            wr_pad[wr_sel] = 1'b1;
        end
        fifo_wr = wr_pad[N-1:0];
    end

    // WAIT_FULL re-runs the decision of the state it stalled, so the held
    // byte is taken on the very first cycle the FIFO has room.
    assign eff_state = (state_q == ST_WAIT_FULL) ? prev_q : state_q;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        addr_d    = addr_q;
        parity_d  = parity_q;
        rx_par_d  = rx_par_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        wr_sel    = addr_q;
        busy_c    = 1'b0;
        dropped_c = 1'b0;

        case (eff_state)
            ST_IDLE: begin
                if (packet_valid) begin
                    if (!hdr_legal) begin
                        dropped_c = 1'b1;
                        state_d   = ST_DROP;
                    end else if (full_pad[hdr_addr]) begin
                        busy_c  = 1'b1;
                        addr_d  = hdr_addr;
                        prev_d  = ST_IDLE;
                        state_d = ST_WAIT_FULL;
                    end else begin
                        wr_en    = 1'b1;
                        wr_sel   = hdr_addr;
                        addr_d   = hdr_addr;
                        parity_d = datain;
                        err_d    = 1'b0;
                        state_d  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (full_pad[addr_q]) begin
                    busy_c  = 1'b1;
                    prev_d  = ST_LOAD;
                    state_d = ST_WAIT_FULL;
                end else begin
                    wr_en  = 1'b1;
                    wr_sel = addr_q;
                    if (packet_valid) begin
                        parity_d = parity_q ^ datain;
                        state_d  = ST_LOAD;
                    end else begin
                        rx_par_d = datain;
                        state_d  = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                busy_c  = 1'b1;
                err_d   = (parity_q != rx_par_q);
                state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (!packet_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            prev_q   <= ST_IDLE;
            addr_q   <= '0;
            parity_q <= '0;
            rx_par_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            addr_q   <= addr_d;
            parity_q <= parity_d;
            rx_par_q <= rx_par_d;
            err_q    <= err_d;
        end
    end

    // Combinational strobes are forced low while reset is held.
    assign busy    = busy_c & resetn;
    assign dropped = dropped_c & resetn;
    assign err     = err_q;

    for (genvar k = 0; k < N; k++) begin : g_ch
        router_fifo #(
            .DW      (DW),
            .DEPTH   (DEPTH),
            .TIMEOUT (TIMEOUT)
        ) u_fifo (
            .clk     (clk),
            .resetn  (resetn),
            .wr_en   (fifo_wr[k]),
            .wr_data (datain),
            .rd_en   (read_enb[k]),
            .rd_data (data_out[k*DW +: DW]),
            .vld     (vld_out[k]),
            .full    (fifo_full[k])
        );
    end

endmodule
